// File: rtl/bus_mux_n_if.sv
// CPU-side and slave-side signals of the PicoRV32 native memory bus around bus_mux_n.
// The mux itself uses the slave modport; the CPU/slave environment uses master.
interface bus_mux_n_if #(
    parameter int NSLAVES = 3
);
    logic [31:0]           i_la_addr;
    logic                  i_la_read;
    logic                  i_la_write;
    logic                  i_valid;
    logic                  o_ready;
    logic [31:0]           o_rdata;
    logic [NSLAVES*32-1:0] i_slave_rdata;
    logic [NSLAVES-1:0]    o_slave_valid;
    logic [NSLAVES-1:0]    i_slave_ready;

    modport slave (
        input  i_la_addr, i_la_read, i_la_write, i_valid, i_slave_rdata, i_slave_ready,
        output o_ready, o_rdata, o_slave_valid
    );

    modport master (
        output i_la_addr, i_la_read, i_la_write, i_valid, i_slave_rdata, i_slave_ready,
        input  o_ready, o_rdata, o_slave_valid
    );
endinterface

// File: rtl/bus_mux_n.sv
// N-slave PicoRV32 bus multiplexer: base/mask decode on the look-ahead address, local
// completion of unmapped and hung accesses, and a sticky first-error capture register.
module bus_mux_n #(
    parameter int                    NSLAVES       = 3,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = {32'h0100_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                    TIMEOUT       = 255,
    parameter logic [31:0]           DEFAULT_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clock,
    input  logic              reset,
    bus_mux_n_if.slave        bus,
    input  logic              i_err_clear,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [31:0]       o_err_addr,
    output logic [7:0]        o_err_count
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int             TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t              r_state;
    logic [TW-1:0]       r_tcnt;
    logic [NSLAVES-1:0]  r_sel;
    logic                r_miss;
    logic [31:0]         r_la_addr;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [31:0]         r_err_addr;
    logic [7:0]          r_err_count;

    logic [NSLAVES-1:0]  w_dec;
    logic                w_active;
    logic                w_slave_hit;
    logic [31:0]         w_sel_rdata;
    logic                w_unmapped_evt;
    logic                w_timeout_evt;
    logic                w_evt;
    logic [1:0]          w_code;
    logic                w_ready;
    logic [31:0]         w_rdata;
    logic [NSLAVES-1:0]  w_slave_valid;

    // Lowest matching index wins, so scan from the top and let lower hits overwrite.
    function automatic logic [NSLAVES-1:0] decode(input logic [31:0] addr);
        logic [NSLAVES-1:0] hit;
        hit = '0;
        for (int k = NSLAVES - 1; k >= 0; k--) begin
            if ((addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                hit    = '0;
                hit[k] = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    assign w_dec          = decode(bus.i_la_addr);
    assign w_active       = (r_state == ST_WAIT) || bus.i_valid;
    assign w_slave_hit    = |(r_sel & bus.i_slave_ready);
    assign w_unmapped_evt = w_active && r_miss;
    // A slave answering on the timeout cycle completes normally.
    assign w_timeout_evt  = (TIMEOUT != 0) && w_active && !r_miss && !w_slave_hit && (r_tcnt == TLAST);
    assign w_evt          = w_unmapped_evt || w_timeout_evt;
    assign w_code         = w_unmapped_evt ? 2'd1 : 2'd2;

    // Read data of the registered one-hot selection.
    always_comb begin
        w_sel_rdata = 32'h0;
        for (int k = 0; k < NSLAVES; k++) begin
            w_sel_rdata = w_sel_rdata | (bus.i_slave_rdata[32*k +: 32] & {32{r_sel[k]}});
        end
    end

    // CPU-facing response and slave strobes, combinational for zero added latency.
    always_comb begin
        w_ready       = 1'b0;
        w_rdata       = 32'h0;
        w_slave_valid = '0;
        if (!w_active) begin
            w_ready = 1'b0;
        end else if (r_miss || w_timeout_evt) begin
            w_ready = 1'b1;
            w_rdata = DEFAULT_RDATA;
        end else begin
            w_slave_valid = r_sel & {NSLAVES{bus.i_valid}};
            w_ready       = w_slave_hit;
            w_rdata       = w_sel_rdata;
        end
    end

    assign bus.o_ready       = w_ready;
    assign bus.o_rdata       = w_rdata;
    assign bus.o_slave_valid = w_slave_valid;

    // Transaction state, timeout counter and look-ahead decode capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_tcnt    <= '0;
            r_sel     <= '0;
            r_miss    <= 1'b0;
            r_la_addr <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= (bus.i_valid && !w_ready) ? ST_WAIT : ST_IDLE;
                ST_WAIT: r_state <= w_ready ? ST_IDLE : ST_WAIT;
                default: r_state <= ST_IDLE;
            endcase
            if (w_ready || !w_active) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            // The completing cycle also samples, so back-to-back strobes are not lost.
            if (((r_state == ST_IDLE) || w_ready) && (bus.i_la_read || bus.i_la_write)) begin
                r_sel     <= w_dec;
                r_miss    <= ~|w_dec;
                r_la_addr <= bus.i_la_addr;
            end
        end
    end

    // Sticky first-error capture; a same-cycle event overrides the clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_err_addr  <= 32'h0;
            r_err_count <= 8'd0;
        end else if (i_err_clear) begin
            if (w_evt) begin
                r_err       <= 1'b1;
                r_err_code  <= w_code;
                r_err_addr  <= r_la_addr;
                r_err_count <= 8'd1;
            end else begin
                r_err       <= 1'b0;
                r_err_code  <= 2'd0;
                r_err_addr  <= 32'h0;
                r_err_count <= 8'd0;
            end
        end else if (w_evt) begin
            if (!r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                r_err_addr <= r_la_addr;
            end
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_err_addr  = r_err_addr;
    assign o_err_count = r_err_count;
endmodule

// File: tb/tb_bus_mux_n.sv
// Scoreboard bench for bus_mux_n: a driver plays CPU and slaves, a reference model predicts
// each completion, and an independent monitor checks every o_ready cycle against it.
module tb_bus_mux_n;
    localparam int          TMO = 8;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        err_clear;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    bus_mux_n_if #(.NSLAVES(3)) bus ();

    bus_mux_n #(.NSLAVES(3), .TIMEOUT(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .i_err_clear (err_clear),
        .o_err       (err),
        .o_err_code  (err_code),
        .o_err_addr  (err_addr),
        .o_err_count (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        int          ncyc;
        logic [2:0]  svalid;
        logic        err;
        logic [1:0]  code;
        logic [31:0] addr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference error register state
    logic        m_err  = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Memory map from the decode table: lowest matching slave, -1 when unmapped.
    function automatic int target(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        if (a[31:16] == 16'h0001) return 1;
        if (a[31:12] == 20'h01000) return 2;
        return -1;
    endfunction

    task automatic model_errors(input bit clr, input bit evt, input logic [1:0] code, input logic [31:0] a);
        if (clr) begin
            m_err = 1'b0; m_code = 2'd0; m_addr = 32'h0; m_cnt = 0;
        end
        if (evt) begin
            if (!m_err) begin
                m_err = 1'b1; m_code = code; m_addr = a;
            end
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    // One CPU access; lat = cycles after valid rises until slave ready, 0 = never.
    task automatic access(input logic [31:0] a, input bit wr, input int lat, input bit clr);
        int          tgt;
        int          n;
        logic [31:0] rd;
        exp_t        e;
        bit          evt;
        logic [1:0]  code;
        tgt  = target(a);
        rd   = $urandom;
        evt  = 1'b0;
        code = 2'd0;
        if (tgt < 0) begin
            e.rdata = DEF; e.ncyc = 1; e.svalid = 3'b000; evt = 1'b1; code = 2'd1;
        end else if (lat != 0 && lat + 1 <= TMO) begin
            e.rdata = rd; e.ncyc = lat + 1; e.svalid = 3'(1 << tgt);
        end else begin
            e.rdata = DEF; e.ncyc = TMO; e.svalid = 3'b000; evt = 1'b1; code = 2'd2;
        end
        model_errors(clr, evt, code, a);
        e.err = m_err; e.code = m_code; e.addr = m_addr; e.cnt = 8'(m_cnt);
        exp_q.push_back(e);

        @(posedge clock); #1;
        bus.i_la_addr = a; bus.i_la_read = !wr; bus.i_la_write = wr;
        @(posedge clock); #1;
        bus.i_la_read = 1'b0; bus.i_la_write = 1'b0; bus.i_la_addr = $urandom;
        bus.i_slave_rdata = {$urandom, $urandom, $urandom};
        if (tgt >= 0) bus.i_slave_rdata[32*tgt +: 32] = rd;
        bus.i_valid = 1'b1;
        err_clear = clr;
        n = 1;
        bus.i_slave_ready = 3'b000;
        while (1) begin
            @(negedge clock);
            if (bus.o_ready) break;
            if (n >= TMO + 4) begin
                check("completion_bound", 32'(n), 32'(e.ncyc));
                break;
            end
            @(posedge clock); #1;
            err_clear = 1'b0;
            n++;
            bus.i_slave_ready = (tgt >= 0 && lat != 0 && n >= lat + 1) ? 3'(1 << tgt) : 3'b000;
        end
        @(posedge clock); #1;
        bus.i_valid = 1'b0; bus.i_slave_ready = 3'b000; err_clear = 1'b0;
    endtask

    // Monitor: counts valid cycles and checks each completion, then the error registers.
    initial begin
        int   vcyc;
        bit   pend;
        exp_t e;
        exp_t pe;
        vcyc = 0;
        pend = 1'b0;
        forever begin
            @(negedge clock);
            if (pend) begin
                check("err_flag",  32'(err),       32'(pe.err));
                check("err_code",  32'(err_code),  32'(pe.code));
                check("err_addr",  err_addr,       pe.addr);
                check("err_count", 32'(err_count), 32'(pe.cnt));
                pend = 1'b0;
            end
            vcyc = bus.i_valid ? vcyc + 1 : 0;
            if (bus.o_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'(bus.o_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata",       bus.o_rdata,             e.rdata);
                    check("ready_cycle", 32'(vcyc),               32'(e.ncyc));
                    check("slave_valid", 32'(bus.o_slave_valid),  32'(e.svalid));
                    pe   = e;
                    pend = 1'b1;
                end
                vcyc = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(bus.o_ready),       32'd0);
        check({tag, "_rdata"},  bus.o_rdata,            32'd0);
        check({tag, "_svalid"}, 32'(bus.o_slave_valid), 32'd0);
        check({tag, "_err"},    32'(err),               32'd0);
        check({tag, "_code"},   32'(err_code),          32'd0);
        check({tag, "_addr"},   err_addr,               32'd0);
        check({tag, "_count"},  32'(err_count),         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; err_clear = 1'b0;
        bus.i_la_addr = 32'h0; bus.i_la_read = 1'b0; bus.i_la_write = 1'b0;
        bus.i_valid = 1'b0; bus.i_slave_rdata = '0; bus.i_slave_ready = 3'b000;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        access(32'h0000_0010, 1'b0, 1, 1'b0);
        access(32'h0200_0000, 1'b1, 1, 1'b0);
        access(32'h0100_0004, 1'b0, 0, 1'b0);
        access(32'h0300_0000, 1'b1, 2, 1'b1);
        access(32'h0100_0008, 1'b0, TMO - 1, 1'b0);

        // Reset while a slave1 access is waiting
        @(posedge clock); #1;
        bus.i_la_addr = 32'h0001_0040; bus.i_la_read = 1'b1;
        @(posedge clock); #1;
        bus.i_la_read = 1'b0; bus.i_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check_all_zero("abort");
        bus.i_valid = 1'b0;
        model_errors(1'b1, 1'b0, 2'd0, 32'h0);
        access(32'h0000_0100, 1'b0, 2, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h0001, 16'($urandom)};
                2:       a = {20'h01000, 12'($urandom)};
                default: a = {16'h0002, 16'($urandom)};
            endcase
            access(a, 1'($urandom_range(0, 1)), $urandom_range(0, 9), ($urandom_range(0, 7) == 0));
        end

        // Saturate the error counter
        for (int i = 0; i < 260; i++) begin
            access({16'h0400, 16'($urandom)}, 1'b1, 1, 1'b0);
        end

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
